divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq_pkg.sv | 17 +
 rtl/divider_seq_if.sv | 25 ++
 rtl/divider_seq_step.sv | 27 ++
 rtl/divider_seq.sv | 148 ++++++++++++++
 tb/tb_divider_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg: FSM state type and encodings shared by the divider files.
// No ports; import with divider_seq_pkg::*.
package divider_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: request/result bundle of the sequential divider.
// master: start, dividend, divider out; quotient, remainder, ready, done,
// div_by_zero in.  slave: the mirror image, used by divider_seq.
interface divider_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divider;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divider,
        input  quotient, remainder, ready, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divider,
        output quotient, remainder, ready, done, div_by_zero
    );
endinterface

// File: rtl/divider_seq_step.sv
// divider_seq_step: one combinational restoring-division step.
// i_pr: {partial remainder, dividend bits / quotient bits}; i_divisor;
// o_pr: shifted partial remainder with the new quotient bit in bit 0.
module divider_seq_step #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] i_pr,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_pr
);
    logic [WIDTH:0]   w_hi;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Upper half after the left shift needs one extra bit: it can reach
    // almost twice the divisor before the subtract.
    assign w_hi = i_pr[2*WIDTH-1:WIDTH-1];
    assign w_ge = (w_hi >= {1'b0, i_divisor});
    // When w_ge the true difference is below the divisor, so W bits suffice.
    assign w_diff = w_hi[WIDTH-1:0] - i_divisor;

    // Vacated low bit collects the quotient; after WIDTH steps the low half
    // is the quotient and the high half the remainder.
    assign o_pr = w_ge ? {w_diff, i_pr[WIDTH-2:0], 1'b1}
                       : {w_hi[WIDTH-1:0], i_pr[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, one quotient bit per cycle.
// Ports: clk, rst (async active-high), bus (divider_seq_if.slave).
// Optional macro DIVIDER_SEQ_SIGNED_EN selects two's-complement operands.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    divider_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_pr;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_q_fix;
    logic [WIDTH-1:0]   r_r_fix;
    logic               r_dbz_fix;
    logic               r_zero_wait;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_ready;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_pr_next;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Most-negative stays as its own bit pattern, which is the correct
    // unsigned magnitude.
    assign w_a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_b_mag = bus.divider[WIDTH-1]  ? -bus.divider  : bus.divider;
`else
    assign w_a_mag = bus.dividend;
    assign w_b_mag = bus.divider;
`endif

    divider_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_pr      (r_pr),
        .i_divisor (r_dvs),
        .o_pr      (w_pr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pr        <= '0;
            r_dvs       <= '0;
            r_q_fix     <= '0;
            r_r_fix     <= '0;
            r_dbz_fix   <= 1'b0;
            r_zero_wait <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_pr    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_dvs   <= w_b_mag;
`ifdef DIVIDER_SEQ_SIGNED_EN
                        r_neg_q <= bus.dividend[WIDTH-1]
                                 ^ bus.divider[WIDTH-1];
                        r_neg_r <= bus.dividend[WIDTH-1];
`endif
                        if (bus.divider == '0) begin
                            r_q_fix     <= '1;
                            r_r_fix     <= bus.dividend;
                            r_dbz_fix   <= 1'b1;
                            // Zero divide dwells one extra cycle in DONE
                            // so its result lands two cycles after accept.
                            r_zero_wait <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dbz_fix   <= 1'b0;
                            r_zero_wait <= 1'b0;
                            r_state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_cnt <= '0;
`ifdef DIVIDER_SEQ_SIGNED_EN
                    r_q_fix <= r_neg_q ? -r_pr[WIDTH-1:0]
                                       :  r_pr[WIDTH-1:0];
                    r_r_fix <= r_neg_r ? -r_pr[2*WIDTH-1:WIDTH]
                                       :  r_pr[2*WIDTH-1:WIDTH];
`else
                    r_q_fix <= r_pr[WIDTH-1:0];
                    r_r_fix <= r_pr[2*WIDTH-1:WIDTH];
`endif
                    r_state <= DONE;
                end
                DONE: begin
                    if (r_zero_wait) begin
                        r_zero_wait <= 1'b0;
                    end else begin
                        r_quotient  <= r_q_fix;
                        r_remainder <= r_r_fix;
                        r_dbz       <= r_dbz_fix;
                        r_done      <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.ready       = r_ready;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed and random checks of divider_seq at
// WIDTH 2, 4, 8, 16 and 32.
module tb_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(2))  b2 ();
    divider_seq_if #(.WIDTH(4))  b4 ();
    divider_seq_if #(.WIDTH(8))  b8 ();
    divider_seq_if #(.WIDTH(16)) b16 ();
    divider_seq_if #(.WIDTH(32)) b32 ();

    divider_seq #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
    divider_seq #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
    divider_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
    divider_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
    divider_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic drv(input int w, input logic s,
                       input logic [63:0] a, input logic [63:0] b);
        case (w)
            2:  begin b2.start = s;  b2.dividend = a[1:0];
                      b2.divider = b[1:0]; end
            4:  begin b4.start = s;  b4.dividend = a[3:0];
                      b4.divider = b[3:0]; end
            8:  begin b8.start = s;  b8.dividend = a[7:0];
                      b8.divider = b[7:0]; end
            16: begin b16.start = s; b16.dividend = a[15:0];
                      b16.divider = b[15:0]; end
            32: begin b32.start = s; b32.dividend = a[31:0];
                      b32.divider = b[31:0]; end
            default: ;
        endcase
    endtask

    function automatic logic [63:0] rd_q(input int w);
        case (w)
            2:  return 64'(b2.quotient);
            4:  return 64'(b4.quotient);
            8:  return 64'(b8.quotient);
            16: return 64'(b16.quotient);
            32: return 64'(b32.quotient);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rd_r(input int w);
        case (w)
            2:  return 64'(b2.remainder);
            4:  return 64'(b4.remainder);
            8:  return 64'(b8.remainder);
            16: return 64'(b16.remainder);
            32: return 64'(b32.remainder);
            default: return 64'd0;
        endcase
    endfunction

    // {ready, done, div_by_zero}
    function automatic logic [2:0] rd_f(input int w);
        case (w)
            2:  return {b2.ready, b2.done, b2.div_by_zero};
            4:  return {b4.ready, b4.done, b4.div_by_zero};
            8:  return {b8.ready, b8.done, b8.div_by_zero};
            16: return {b16.ready, b16.done, b16.div_by_zero};
            32: return {b32.ready, b32.done, b32.div_by_zero};
            default: return 3'b000;
        endcase
    endfunction

    // Called just after a negedge with the DUT idle; lat counts posedges
    // from the accepting edge (0) to the edge that raised done.
    task automatic run_op(input int w, input logic [63:0] a,
                          input logic [63:0] b,
                          output logic [63:0] q, output logic [63:0] r,
                          output logic dbz, output int lat);
        drv(w, 1'b1, a, b);
        @(negedge clk);
        drv(w, 1'b0, a, b);
        lat = 0;
        while (rd_f(w)[1] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat >= 200) begin
            n_errors++;
            $display("FAIL timeout w=%0d: no done, required within 200", w);
        end
        q   = rd_q(w);
        r   = rd_r(w);
        dbz = rd_f(w)[0];
    endtask

    task automatic ref_div(input int w, input logic [63:0] a,
                           input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dbz);
        logic [63:0] m;
        longint      sa;
        longint      sb;
        m = mask(w);
        a = a & m;
        b = b & m;
        if (b == 64'd0) begin
            q = m; r = a; dbz = 1'b1;
        end else begin
            dbz = 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            sa = a[w-1] ? longint'(a | ~m) : longint'(a);
            sb = b[w-1] ? longint'(b | ~m) : longint'(b);
            q  = 64'(sa / sb) & m;
            r  = 64'(sa % sb) & m;
`else
            sa = 0; sb = 0;
            q  = a / b;
            r  = a % b;
`endif
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b16.quotient !== 16'h0) begin n_errors++;
            $display("FAIL reset_q: got %0h required 0", b16.quotient); end
        n_checks++;
        if (b16.remainder !== 16'h0) begin n_errors++;
            $display("FAIL reset_r: got %0h required 0", b16.remainder); end
        n_checks++;
        if (rd_f(16) !== 3'b100) begin n_errors++;
            $display("FAIL reset_flags: got %b required 100", rd_f(16)); end
        n_checks++;
        if (rd_f(4) !== 3'b100) begin n_errors++;
            $display("FAIL reset_flags_w4: got %b required 100", rd_f(4)); end
    endtask

    task automatic test_w4_basic;
        int lat;
        drv(4, 1'b1, 64'd11, 64'd3);
        @(negedge clk);
        drv(4, 1'b0, 64'd11, 64'd3);
        n_checks++;
        if (b4.ready !== 1'b0) begin n_errors++;
            $display("FAIL w4_busy: ready got %b required 0", b4.ready); end
        lat = 0;
        while (b4.done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 6) begin n_errors++;
            $display("FAIL w4_latency: got %0d required 6", lat); end
        n_checks++;
        if (b4.quotient !== 4'd3) begin n_errors++;
            $display("FAIL w4_q: got %0d required 3", b4.quotient); end
        n_checks++;
        if (b4.remainder !== 4'd2) begin n_errors++;
            $display("FAIL w4_r: got %0d required 2", b4.remainder); end
        n_checks++;
        if (b4.ready !== 1'b1) begin n_errors++;
            $display("FAIL w4_ready: got %b required 1", b4.ready); end
        @(negedge clk);
        n_checks++;
        if (b4.done !== 1'b0) begin n_errors++;
            $display("FAIL w4_pulse: done got %b required 0", b4.done); end
    endtask

    task automatic test_back_to_back;
        int lat;
        drv(16, 1'b1, 64'd65535, 64'd1);
        @(negedge clk);
        lat = 0;
        while (b16.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 18 || b16.quotient !== 16'hFFFF ||
            b16.remainder !== 16'h0) begin n_errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0h r=%0h required 18 ffff 0",
                     lat, b16.quotient, b16.remainder); end
        drv(16, 1'b1, 64'd1000, 64'd7);
        @(negedge clk);
        drv(16, 1'b0, 64'd1000, 64'd7);
        n_checks++;
        if (b16.ready !== 1'b0) begin n_errors++;
            $display("FAIL b2b_accept: ready got %b required 0", b16.ready); end
        lat = 0;
        while (b16.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 18) begin n_errors++;
            $display("FAIL b2b_latency: got %0d required 18", lat); end
        n_checks++;
        if (b16.quotient !== 16'd142 || b16.remainder !== 16'd6) begin
            n_errors++;
            $display("FAIL b2b_second: got %0d r %0d required 142 r 6",
                     b16.quotient, b16.remainder); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        logic [63:0] q, r;
        logic        z;
        int          lat;
        run_op(16, 64'd100, 64'd0, q, r, z, lat);
        n_checks++;
        if (q !== 64'hFFFF || r !== 64'd100) begin n_errors++;
            $display("FAIL dz_result: got %0h r %0h required ffff r 64", q, r); end
        n_checks++;
        if (z !== 1'b1) begin n_errors++;
            $display("FAIL dz_flag: got %b required 1", z); end
        n_checks++;
        if (lat != 2) begin n_errors++;
            $display("FAIL dz_latency: got %0d required 2", lat); end
        @(negedge clk);
        run_op(16, 64'd1000, 64'd7, q, r, z, lat);
        n_checks++;
        if (z !== 1'b0 || q !== 64'd142 || r !== 64'd6) begin n_errors++;
            $display("FAIL dz_clear: got z=%b %0d r %0d required 0 142 r 6",
                     z, q, r); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat;
        drv(16, 1'b1, 64'd1000, 64'd7);
        @(negedge clk);
        drv(16, 1'b0, 64'd1000, 64'd7);
        lat = 0;
        while (b16.done !== 1'b1 && lat < 100) begin
            if (lat == 3) drv(16, 1'b1, 64'd50, 64'd5);
            else if (lat == 4) drv(16, 1'b0, 64'd50, 64'd5);
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 18) begin n_errors++;
            $display("FAIL ign_latency: got %0d required 18", lat); end
        n_checks++;
        if (b16.quotient !== 16'd142 || b16.remainder !== 16'd6) begin
            n_errors++;
            $display("FAIL ign_result: got %0d r %0d required 142 r 6",
                     b16.quotient, b16.remainder); end
        @(negedge clk);
        n_checks++;
        if (rd_f(16) !== 3'b100) begin n_errors++;
            $display("FAIL ign_idle: flags got %b required 100", rd_f(16)); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        drv(16, 1'b1, 64'd500, 64'd3);
        @(negedge clk);
        drv(16, 1'b0, 64'd500, 64'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_f(16) !== 3'b100) begin n_errors++;
            $display("FAIL rstmid_flags: got %b required 100", rd_f(16)); end
        n_checks++;
        if (b16.quotient !== 16'h0 || b16.remainder !== 16'h0) begin
            n_errors++;
            $display("FAIL rstmid_outs: got %0h r %0h required 0 r 0",
                     b16.quotient, b16.remainder); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (22) begin
            @(negedge clk);
            if (b16.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++;
            $display("FAIL rstmid_nodone: done seen %b required 0", seen); end
    endtask

    task automatic test_signed;
        logic [63:0] q, r, eq, er;
        logic        z;
        int          lat;
        run_op(16, 64'hFFF9, 64'd2, q, r, z, lat);
`ifdef DIVIDER_SEQ_SIGNED_EN
        eq = 64'hFFFD; er = 64'hFFFF;
`else
        eq = 64'h7FFC; er = 64'h0001;
`endif
        n_checks++;
        if (q !== eq || r !== er) begin n_errors++;
            $display("FAIL neg7_div2: got %0h r %0h required %0h r %0h",
                     q, r, eq, er); end
        n_checks++;
        if (lat != 18) begin n_errors++;
            $display("FAIL neg7_latency: got %0d required 18", lat); end
        @(negedge clk);
        run_op(16, 64'h8000, 64'hFFFF, q, r, z, lat);
`ifdef DIVIDER_SEQ_SIGNED_EN
        eq = 64'h8000; er = 64'h0000;
`else
        eq = 64'h0000; er = 64'h8000;
`endif
        n_checks++;
        if (q !== eq || r !== er) begin n_errors++;
            $display("FAIL mostneg_div: got %0h r %0h required %0h r %0h",
                     q, r, eq, er); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int          widths [4] = '{2, 8, 16, 32};
        logic [63:0] a, b, q, r, eq, er, m;
        logic        z, ez;
        int          lat, elat, w;
        for (int wi = 0; wi < 4; wi++) begin
            w = widths[wi];
            m = mask(w);
            for (int n = 0; n < 15; n++) begin
                a = {32'($urandom), 32'($urandom)} & m;
                case ($urandom_range(0, 7))
                    0:       b = 64'd0;
                    1:       b = 64'd1;
                    2, 3:    b = 64'($urandom_range(1, 7)) & m;
                    default: b = {32'($urandom), 32'($urandom)} & m;
                endcase
                ref_div(w, a, b, eq, er, ez);
                run_op(w, a, b, q, r, z, lat);
                elat = ez ? 2 : w + 2;
                n_checks++;
                if (q !== eq || r !== er || z !== ez) begin n_errors++;
                    $display("FAIL rand_w%0d %0h/%0h: got %0h r %0h z %b required %0h r %0h z %b",
                             w, a, b, q, r, z, eq, er, ez); end
                n_checks++;
                if (lat != elat) begin n_errors++;
                    $display("FAIL rand_lat_w%0d: got %0d required %0d",
                             w, lat, elat); end
`ifndef DIVIDER_SEQ_SIGNED_EN
                if (b != 64'd0) begin
                    n_checks++;
                    if (((q * b + r) & m) !== a || r >= b) begin n_errors++;
                        $display("FAIL rand_ident_w%0d %0h/%0h: got q=%0h r=%0h",
                                 w, a, b, q, r); end
                end
`endif
                @(negedge clk);
            end
        end
    endtask

    initial begin
        drv(2, 1'b0, 64'd0, 64'd0);
        drv(4, 1'b0, 64'd0, 64'd0);
        drv(8, 1'b0, 64'd0, 64'd0);
        drv(16, 1'b0, 64'd0, 64'd0);
        drv(32, 1'b0, 64'd0, 64'd0);
        test_reset;
        test_w4_basic;
        test_back_to_back;
        test_div_zero;
        test_ignore_start;
        test_reset_mid;
        test_signed;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
